demorgan_sweeper: RTL and testbench

Self-checking stimulus/response stage wrapped around the `demorgan` block. It drives `A`/`B` through all four input combinations, waits a programmable settle time, then samples and checks the six `demorgan` outputs against De Morgan's laws. It accumulates mismatches and reports pass/fail with a done pulse. It sits directly upstream of `demorgan` (feeding its inputs) and directly downstream of it (consuming its outputs), replacing hand-stepped truth-table checks with a synthesizable sequencer.

---
 rtl/demorgan_sweeper.sv | 153 +++++++++++++++
 tb/tb_demorgan_sweeper.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demorgan_sweeper.sv
// Sequencer that sweeps all four {A,B} combinations into a demorgan block,
// checks its six outputs after a settle time and reports mismatches.
module demorgan_sweeper #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             nA,
  input  logic             nB,
  input  logic             n_AandB,
  input  logic             nAornB,
  input  logic             n_AorB,
  input  logic             nAandnB,
  output logic             A,
  output logic             B,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam int SUM_W = ERR_W + 3;
  localparam logic [SUM_W-1:0] ERR_MAX = SUM_W'({ERR_W{1'b1}});

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fail_q, fail_d;
  logic             pass_q, pass_d;

  logic [5:0]       expected;
  logic [5:0]       observed;
  logic [5:0]       mismatch;
  logic [2:0]       miss_cnt;
  logic [SUM_W-1:0] err_sum;
  logic [ERR_W-1:0] err_sat;

  // Expected outputs are derived from the registered stimulus currently applied.
  always_comb begin
    expected = {~a_q, ~b_q, ~(a_q & b_q), ~a_q | ~b_q, ~(a_q | b_q), ~a_q & ~b_q};
    observed = {nA, nB, n_AandB, nAornB, n_AorB, nAandnB};
    mismatch = expected ^ observed;
    miss_cnt = 3'd0;
    for (int i = 0; i < 6; i++) begin
      miss_cnt = miss_cnt + {2'b00, mismatch[i]};
    end
    err_sum = SUM_W'(err_q) + SUM_W'(miss_cnt);
    err_sat = (err_sum > ERR_MAX) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    a_d     = 1'b0;
    b_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          idx_d   = 2'd0;
          cnt_d   = SETTLE_LOAD;
          err_d   = '0;
          fail_d  = 4'b0000;
          pass_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SAMPLE: begin
        err_d = err_sat;
        if (|mismatch) begin
          fail_d[idx_q] = 1'b1;
        end
        if (idx_q == 2'd3) begin
          state_d = DONE;
          pass_d  = (err_sat == '0);
        end else begin
          state_d = SETTLE;
          idx_d   = idx_q + 2'd1;
          cnt_d   = SETTLE_LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Stimulus follows the vector index only while a sweep is active.
    if (state_d == SETTLE || state_d == SAMPLE) begin
      a_d = idx_d[1];
      b_d = idx_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      err_q   <= '0;
      fail_q  <= 4'b0000;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_demorgan_sweeper.sv
// Bench for demorgan_sweeper: two instances (S=1/ERR_W=5 and S=3/ERR_W=3)
// each fed by a faultable demorgan model.
module tb_demorgan_sweeper;

  logic clk;
  logic reset;
  logic start_r [2];
  int   fm [2];
  logic [5:0] mask [2][4];

  logic a0, b0, busy0, done0, pass0;
  logic [4:0] err0;
  logic [3:0] fv0;
  logic a1, b1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] fv1;
  logic [5:0] dm0, dm1;

  logic       a_w [2], b_w [2], busy_w [2], done_w [2], pass_w [2];
  logic [4:0] err_w [2];
  logic [3:0] fv_w [2];

  int n_cmp;
  int n_fail;

  typedef struct {
    int         dut;
    int         mode;
    logic [4:0] err;
    logic [3:0] fv;
    logic       pass;
  } vec_t;

  vec_t tbl [6];

  demorgan_sweeper #(.SETTLE_CYCLES(1), .ERR_W(5)) dut0 (
    .clk(clk), .reset(reset), .start(start_r[0]),
    .nA(dm0[5]), .nB(dm0[4]), .n_AandB(dm0[3]), .nAornB(dm0[2]),
    .n_AorB(dm0[1]), .nAandnB(dm0[0]),
    .A(a0), .B(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fv0)
  );

  demorgan_sweeper #(.SETTLE_CYCLES(3), .ERR_W(3)) dut1 (
    .clk(clk), .reset(reset), .start(start_r[1]),
    .nA(dm1[5]), .nB(dm1[4]), .n_AandB(dm1[3]), .nAornB(dm1[2]),
    .n_AorB(dm1[1]), .nAandnB(dm1[0]),
    .A(a1), .B(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Faultable demorgan: 0 ideal, 1 n_AandB stuck-1, 2 nA/nB swapped,
  // 3 all stuck-0, 4 ideal xor a per-vector flip mask.
  function automatic logic [5:0] dm_model(input logic a, input logic b,
                                          input int mode, input logic [5:0] flip);
    logic [5:0] v;
    v = {~a, ~b, ~(a & b), ~a | ~b, ~(a | b), ~a & ~b};
    case (mode)
      1: v[3] = 1'b1;
      2: v = {v[4], v[5], v[3:0]};
      3: v = 6'b000000;
      4: v = v ^ flip;
      default: ;
    endcase
    return v;
  endfunction

  always_comb begin
    dm0 = dm_model(a0, b0, fm[0], mask[0][{a0, b0}]);
    dm1 = dm_model(a1, b1, fm[1], mask[1][{a1, b1}]);
    a_w[0] = a0;  b_w[0] = b0;  busy_w[0] = busy0; done_w[0] = done0;
    pass_w[0] = pass0; err_w[0] = err0; fv_w[0] = fv0;
    a_w[1] = a1;  b_w[1] = b1;  busy_w[1] = busy1; done_w[1] = done1;
    pass_w[1] = pass1; err_w[1] = {2'b00, err1}; fv_w[1] = fv1;
  end

  task automatic check_output(input string name, input logic [31:0] got,
                              input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // One sweep on instance d with settle s; optional start pokes while busy/DONE.
  task automatic apply_stimulus(input int d, input int s, input logic [4:0] exp_err,
                                input logic [3:0] exp_fv, input logic exp_pass,
                                input bit poke_busy, input bit poke_done);
    int c;
    bit seen;
    logic [1:0] vec;
    @(negedge clk);
    start_r[d] = 1'b1;
    @(posedge clk); #1;
    start_r[d] = 1'b0;
    check_output("busy_at_start", busy_w[d], 1);
    check_output("err_cleared_at_start", err_w[d], 0);
    check_output("ab_vec0", {a_w[d], b_w[d]}, 0);
    seen = 1'b0;
    for (c = 1; c <= 4 * (s + 1) + 4; c++) begin
      if (poke_busy && c == 3) start_r[d] = 1'b1;
      if (poke_busy && c == 4) start_r[d] = 1'b0;
      @(posedge clk); #1;
      if (done_w[d]) begin
        seen = 1'b1;
        break;
      end
      if (c < 4 * (s + 1)) begin
        vec = 2'(c / (s + 1));
        check_output("ab_vector", {a_w[d], b_w[d]}, vec);
        check_output("busy_during_sweep", busy_w[d], 1);
      end
    end
    start_r[d] = 1'b0;
    check_output("done_latency", seen ? c : -1, 4 * (s + 1));
    check_output("busy_in_done", busy_w[d], 0);
    check_output("pass", pass_w[d], exp_pass);
    check_output("err_count", err_w[d], exp_err);
    check_output("fail_vec", fv_w[d], exp_fv);
    if (poke_done) start_r[d] = 1'b1;
    @(posedge clk); #1;
    start_r[d] = 1'b0;
    check_output("done_one_cycle", done_w[d], 0);
    check_output("busy_after_done", busy_w[d], 0);
    check_output("pass_held", pass_w[d], exp_pass);
    if (poke_done) begin
      @(posedge clk); #1;
      check_output("start_in_done_ignored", busy_w[d], 0);
      check_output("err_held_idle", err_w[d], exp_err);
    end
  endtask

  initial begin
    int c;
    int dones;
    int total;
    int emax;
    logic [3:0] efv;
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b1;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    fm[0] = 0;
    fm[1] = 0;
    for (int d = 0; d < 2; d++)
      for (int v = 0; v < 4; v++) mask[d][v] = 6'd0;

    tbl[0] = '{0, 0, 5'd0,  4'b0000, 1'b1};
    tbl[1] = '{0, 1, 5'd1,  4'b1000, 1'b0};
    tbl[2] = '{0, 2, 5'd4,  4'b0110, 1'b0};
    tbl[3] = '{0, 3, 5'd12, 4'b0111, 1'b0};
    tbl[4] = '{1, 3, 5'd7,  4'b0111, 1'b0};
    tbl[5] = '{1, 0, 5'd0,  4'b0000, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_output("reset_ab", {a_w[d], b_w[d]}, 0);
      check_output("reset_busy", busy_w[d], 0);
      check_output("reset_done", done_w[d], 0);
      check_output("reset_pass", pass_w[d], 0);
      check_output("reset_err", err_w[d], 0);
      check_output("reset_fv", fv_w[d], 0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fm[tbl[i].dut] = tbl[i].mode;
      apply_stimulus(tbl[i].dut, tbl[i].dut ? 3 : 1, tbl[i].err, tbl[i].fv,
                     tbl[i].pass, 1'b0, 1'b0);
    end

    // start pokes while busy and in DONE must not disturb the sweep
    fm[0] = 2;
    apply_stimulus(0, 1, 5'd4, 4'b0110, 1'b0, 1'b1, 1'b1);

    // reset during vector-2 settle, with errors already accumulated
    fm[0] = 2;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_output("pre_reset_ab", {a_w[0], b_w[0]}, 2);
    check_output("pre_reset_err", err_w[0], 2);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_output("midreset_busy", busy_w[0], 0);
    check_output("midreset_ab", {a_w[0], b_w[0]}, 0);
    check_output("midreset_err", err_w[0], 0);
    check_output("midreset_fv", fv_w[0], 0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_w[0]) dones++;
    end
    check_output("no_done_after_reset", dones, 0);
    fm[0] = 0;
    apply_stimulus(0, 1, 5'd0, 4'b0000, 1'b1, 1'b0, 1'b0);

    // start held high: back-to-back sweeps with one IDLE cycle between
    fm[0] = 2;
    @(negedge clk);
    start_r[0] = 1'b1;
    for (c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done_w[0]) break;
    end
    check_output("held_first_done", done_w[0], 1);
    @(posedge clk); #1;
    check_output("held_idle_gap", busy_w[0], 0);
    @(posedge clk); #1;
    check_output("held_restart_busy", busy_w[0], 1);
    check_output("held_err_cleared", err_w[0], 0);
    for (c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (done_w[0]) break;
    end
    check_output("held_second_latency", c, 8);
    check_output("held_second_err", err_w[0], 4);
    check_output("held_second_fv", fv_w[0], 4'b0110);
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (3) @(posedge clk);

    // random per-vector faults against a counting reference model
    for (int it = 0; it < 12; it++) begin
      int d;
      d = it % 2;
      emax = d ? 7 : 31;
      fm[d] = 4;
      total = 0;
      efv = 4'b0000;
      for (int v = 0; v < 4; v++) begin
        mask[d][v] = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 2) == 0 || it == 0 || it == 1) mask[d][v] = 6'd0;
        total += $countones(mask[d][v]);
        if (mask[d][v] != 6'd0) efv[v] = 1'b1;
      end
      if (total > emax) total = emax;
      apply_stimulus(d, d ? 3 : 1, 5'(total), efv, total == 0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
